// File: rtl/key_debounce_pulse.sv
// key_debounce_pulse
//   Debounces three raw key inputs {E,F,G} and reports accepted transitions.
//   Each key is synchronized by two flops and then filtered by its own
//   counter. A changed level has to persist for DEBOUNCE_CYCLES consecutive
//   edges before it is accepted.
//
// Ports
//   sys_clk      system clock; all state changes on its rising edge
//   sys_rst      asynchronous, active-high reset
//   key_in       raw key levels, bit2=E, bit1=F, bit0=G (1 = pressed)
//   key_level    debounced stable levels, same bit order as key_in
//   key_press    one-cycle pulse per key on an accepted 0->1 transition
//   key_release  one-cycle pulse per key on an accepted 1->0 transition
//   key_valid    high while any key_press bit is high
//   key_code     key of the most recent key_valid: 1=E, 2=F, 3=G, 0=none yet
//   multi_press  high while key_valid is high and two or more keys pressed
module key_debounce_pulse #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 16
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic [2:0] key_in,
  output logic [2:0] key_level,
  output logic [2:0] key_press,
  output logic [2:0] key_release,
  output logic       key_valid,
  output logic [1:0] key_code,
  output logic       multi_press
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [2:0]       sync1;
  logic [2:0]       sync2;
  logic [CNT_W-1:0] cnt [3];
  logic [2:0]       toggle;
  logic [2:0]       next_press;

  // A key toggles on the edge where its mismatch has already been counted
  // DEBOUNCE_CYCLES-1 times; this same condition clears the counter, so the
  // counter cannot exceed CNT_MAX or wrap.
  always_comb begin
    toggle = '0;
    for (int i = 0; i < 3; i++) begin
      toggle[i] = (sync2[i] != key_level[i]) && (cnt[i] == CNT_MAX);
    end
    next_press = toggle & ~key_level;
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= key_in;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      for (int i = 0; i < 3; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if ((sync2[i] == key_level[i]) || toggle[i]) begin
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      key_level   <= '0;
      key_press   <= '0;
      key_release <= '0;
    end else begin
      key_level   <= key_level ^ toggle;
      key_press   <= next_press;
      key_release <= toggle & key_level;
    end
  end

  // key_code is registered from the next-cycle press vector so the new code
  // is visible in the same cycle as key_valid.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      key_code <= 2'd0;
    end else if (next_press[2]) begin
      key_code <= 2'd1;
    end else if (next_press[1]) begin
      key_code <= 2'd2;
    end else if (next_press[0]) begin
      key_code <= 2'd3;
    end
  end

  assign key_valid   = |key_press;
  assign multi_press = (key_press[2] & key_press[1]) |
                       (key_press[2] & key_press[0]) |
                       (key_press[1] & key_press[0]);

endmodule

// File: tb/tb_key_debounce_pulse.sv
module tb_key_debounce_pulse;

  localparam int D = 4;

  logic       sys_clk = 1'b0;
  logic       sys_rst;
  logic [2:0] key_in;
  logic [2:0] key_level, key_press, key_release;
  logic       key_valid, multi_press;
  logic [1:0] key_code;

  int vectors = 0;
  int miscompares = 0;

  key_debounce_pulse #(.DEBOUNCE_CYCLES(D), .CNT_W(16)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .key_in(key_in),
    .key_level(key_level), .key_press(key_press), .key_release(key_release),
    .key_valid(key_valid), .key_code(key_code), .multi_press(multi_press)
  );

  always #5 sys_clk = ~sys_clk;

  // Reference model: raw samples travel through a two-stage delay; a key's
  // stable level flips once the last D synchronized samples all disagree
  // with it.
  logic [2:0] m_p1, m_p2, m_lvl, m_press, m_rel;
  logic [1:0] m_code;
  logic [2:0] m_hist [D];

  task automatic model_reset();
    m_p1 = '0; m_p2 = '0; m_lvl = '0; m_press = '0; m_rel = '0; m_code = '0;
    for (int j = 0; j < D; j++) m_hist[j] = '0;
  endtask

  task automatic model_edge(input logic [2:0] raw);
    logic [2:0] s2, tog;
    s2 = m_p2; m_p2 = m_p1; m_p1 = raw;
    for (int j = D - 1; j > 0; j--) m_hist[j] = m_hist[j-1];
    m_hist[0] = s2;
    tog = 3'b111;
    for (int j = 0; j < D; j++) tog = tog & (m_hist[j] ^ m_lvl);
    m_press = tog & ~m_lvl;
    m_rel   = tog & m_lvl;
    m_lvl   = m_lvl ^ tog;
    if (m_press[2])      m_code = 2'd1;
    else if (m_press[1]) m_code = 2'd2;
    else if (m_press[0]) m_code = 2'd3;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_outputs(input string tag);
    logic [15:0] obs, exp;
    logic e_multi;
    e_multi = ($countones(m_press) >= 2);
    obs = {3'b0, key_level, key_press, key_release, key_valid, key_code, multi_press};
    exp = {3'b0, m_lvl, m_press, m_rel, |m_press, m_code, e_multi};
    chk(tag, obs, exp);
  endtask

  // Drive a raw level, take one rising edge, compare 1 ns later.
  task automatic step(input logic [2:0] k, input string tag);
    key_in = k;
    @(posedge sys_clk);
    model_edge(k);
    #1;
    chk_outputs(tag);
  endtask

  // 3 ns reset pulse placed mid-cycle; outputs must clear at once.
  task automatic do_reset();
    #2;
    sys_rst = 1'b1;
    model_reset();
    #1;
    chk_outputs("reset_async");
    #2;
    sys_rst = 1'b0;
  endtask

  initial begin
    int first, cnt_a, cnt_b;
    sys_rst = 1'b1;
    key_in  = 3'b000;
    model_reset();
    #1;
    chk_outputs("reset_init");
    #2;
    sys_rst = 1'b0;
    for (int i = 0; i < 3; i++) step(3'b000, "idle");

    // E held 100 ns, then released
    first = 0;
    for (int i = 1; i <= 10; i++) begin
      step(3'b100, "e_hold");
      if (first == 0 && key_press == 3'b100) first = i;
    end
    chk("e_press_latency", 16'(first), 16'd6);
    first = 0;
    for (int i = 1; i <= 10; i++) begin
      step(3'b000, "e_release");
      if (first == 0 && key_release == 3'b100) first = i;
    end
    chk("e_release_latency", 16'(first), 16'd6);

    // single-cycle bounce on F, five times
    cnt_a = 0;
    for (int i = 0; i < 5; i++) begin
      step(3'b010, "bounce");
      if (key_press != 0 || key_release != 0) cnt_a++;
      step(3'b000, "bounce");
      if (key_press != 0 || key_release != 0) cnt_a++;
    end
    for (int i = 0; i < 6; i++) begin
      step(3'b000, "bounce_tail");
      if (key_press != 0 || key_release != 0) cnt_a++;
    end
    chk("bounce_pulses", 16'(cnt_a), 16'd0);
    chk("bounce_level", 16'(key_level), 16'd0);

    // F and G together
    cnt_a = 0;
    for (int i = 0; i < 8; i++) begin
      step(3'b011, "fg_hold");
      if (key_valid) cnt_a++;
    end
    chk("fg_valid_count", 16'(cnt_a), 16'd1);
    chk("fg_code", 16'(key_code), 16'd2);
    for (int i = 0; i < 8; i++) step(3'b000, "fg_release");

    // reset 3 edges into a held G, key still held after release
    for (int i = 0; i < 3; i++) step(3'b001, "g_pre_reset");
    do_reset();
    first = 0;
    for (int i = 1; i <= 8; i++) begin
      step(3'b001, "g_post_reset");
      if (first == 0 && key_press[0]) first = i;
    end
    chk("g_reset_latency", 16'(first), 16'd6);
    for (int i = 0; i < 8; i++) step(3'b000, "g_release");

    // reset truncating a live press pulse
    for (int i = 0; i < 6; i++) step(3'b001, "trunc_hold");
    chk("trunc_pulse_live", 16'(key_press), 16'd1);
    do_reset();
    for (int i = 0; i < 8; i++) step(3'b000, "trunc_after");

    // G held 1000 ns: exactly one press, no auto-repeat
    cnt_a = 0; cnt_b = 0;
    for (int i = 0; i < 100; i++) begin
      step(3'b001, "g_long");
      if (key_press[0]) cnt_a++;
      if (key_level[0]) cnt_b++;
    end
    chk("g_long_presses", 16'(cnt_a), 16'd1);
    chk("g_long_level_cycles", 16'(cnt_b), 16'd95);
    for (int i = 0; i < 8; i++) step(3'b000, "g_long_release");

    // randomized segments, occasional reset
    for (int s = 0; s < 60; s++) begin
      logic [2:0] k;
      int len;
      k   = 3'($urandom_range(0, 7));
      len = $urandom_range(1, 8);
      for (int i = 0; i < len; i++) step(k, "random");
      if ($urandom_range(0, 19) == 0) do_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/key_debounce_pulse.md
KEY_DEBOUNCE_PULSE -- requirements
Module: key_debounce_pulse

Interface
REQ-001 The block SHALL expose parameter DEBOUNCE_CYCLES, default 4, meaning the number of consecutive sampled edges a changed key level must hold before it is accepted (legal 2..65535).
REQ-002 The block SHALL expose parameter CNT_W, default 16, meaning the width of each per-key debounce counter.
REQ-003 sys_clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 sys_rst  input  1  asynchronous, active-high reset.
REQ-005 key_in  input  3  raw asynchronous key levels {E,F,G}, where bit2=E, bit1=F, bit0=G, and 1 means pressed.
REQ-006 key_level  output  3  debounced stable key levels, same bit order as key_in.
REQ-007 key_press  output  3  one-cycle pulse per key on an accepted 0->1 transition.
REQ-008 key_release  output  3  one-cycle pulse per key on an accepted 1->0 transition.
REQ-009 key_valid  output  1  one-cycle strobe when at least one key_press bit is high.
REQ-010 key_code  output  2  encoded key of the most recent key_valid: 2'd1=E, 2'd2=F, 2'd3=G; 2'd0 means none since reset.
REQ-011 multi_press  output  1  high for the key_valid cycle when more than one key_press bit is high.

Function
REQ-012 Each key_in bit SHALL pass through a two-flop synchronizer (sync1, sync2) before any other use.
REQ-013 Each key SHALL own an independent counter cnt[i], compared against the key's stable level key_level[i].
REQ-014 When sync2[i]==key_level[i] on an edge, cnt[i] SHALL clear to 0.
REQ-015 When sync2[i]!=key_level[i] and cnt[i]<DEBOUNCE_CYCLES-1, cnt[i] SHALL increment by 1.
REQ-016 When sync2[i]!=key_level[i] and cnt[i]==DEBOUNCE_CYCLES-1, the following SHALL happen on the same edge: key_level[i] toggles and cnt[i] clears.
REQ-017 On the edge where key_level[i] rises, key_press[i] SHALL be 1 for exactly that following cycle; a falling edge SHALL assert key_release[i] the same way; otherwise both bits are 0.
REQ-018 Latency: a key_in level stable from before edge k SHALL appear on key_level/key_press after edge k+1+DEBOUNCE_CYCLES.
REQ-019 Any sync2 excursion shorter than DEBOUNCE_CYCLES consecutive edges SHALL produce no change on any output.
REQ-020 key_valid SHALL be asserted in the same cycle as the key_press pulse(s), computed as the OR of the key_press bits.
REQ-021 key_code SHALL update on key_valid using priority E>F>G, and SHALL otherwise hold its value.
REQ-022 multi_press SHALL be 1 only when key_valid is 1 and two or more key_press bits are set.
REQ-023 The counter SHALL saturate logic-free, i.e. it never exceeds DEBOUNCE_CYCLES-1 and never wraps.
REQ-024 Holding a key indefinitely SHALL produce exactly one key_press, with no auto-repeat.
REQ-025 Keys SHALL be fully independent; a bounce on one key SHALL NOT affect another key's counter.

Reset
REQ-026 While sys_rst is 1, the following SHALL be forced to 0 asynchronously: sync1, sync2, cnt, key_level, key_press, key_release, key_valid, key_code, multi_press.
REQ-027 Reset asserted mid-count SHALL discard the partial count; after release, a still-held key SHALL need the full 2+DEBOUNCE_CYCLES edges to register.
REQ-028 A key already held high across reset release SHALL produce a key_press after the normal latency.
REQ-029 A pulse truncated by reset SHALL NOT be extended.

Verification (DEBOUNCE_CYCLES=4, 10 ns clock)
REQ-030 Reset pulse of 3 ns, then idle -> all outputs 0, key_code=0.
REQ-031 Scenario: E held for 100 ns -> key_press=3'b100, key_valid=1, and key_code=1 for one cycle, 6 edges after the first sample; key_level[2]=1 until release; then one key_release[2] pulse 6 edges after the release is sampled.
REQ-032 Scenario: key_in toggled 10 ns high, 10 ns low, repeated 5 times -> no key_press, no key_release, and key_level unchanged.
REQ-033 Scenario: F and G rising in the same cycle and held -> a single key_valid with key_press=3'b011, key_code=2, multi_press=1.
REQ-034 Scenario: sys_rst asserted 3 edges into a held G -> all outputs 0 immediately; after release, key_press[0] occurs 6 edges later.
REQ-035 Scenario: G held for 1000 ns -> exactly one key_press[0] pulse, with key_level[0] high throughout.
